// File: rtl/mem_port_arbiter.sv
// N_REQ-to-1 memory port arbiter with a fixed-latency response tag pipeline and per-requester kill.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed highest-index priority.
module mem_port_arbiter #(
  parameter int N_REQ  = 2,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*AW-1:0]     req_addr,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*DW-1:0]     req_wdata,
  input  logic [N_REQ*(DW/8)-1:0] req_be,
  input  logic [N_REQ-1:0]        rsp_kill,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic                    rsp_we,
  output logic [DW-1:0]           rsp_data,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [AW-1:0]           mem_addr,
  output logic [DW-1:0]           mem_wdata,
  output logic [DW/8-1:0]         mem_be,
  input  logic [DW-1:0]           mem_rdata
);

  localparam int BW = DW / 8;
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] gnt_s;

`ifdef MEM_ARB_RR_EN
  localparam int SW = IW + 1;

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] gidx_s;
  logic [IW-1:0] cand_s;
  logic [SW-1:0] sum_s;
  logic          found_s;

  // Round-robin search starting at the pointer, wrapping from N_REQ-1 to 0
  always_comb begin
    gnt_s   = '0;
    gidx_s  = '0;
    cand_s  = '0;
    sum_s   = '0;
    found_s = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      sum_s  = SW'(ptr_q) + SW'(k);
      cand_s = (sum_s >= SW'(N_REQ)) ? IW'(sum_s - SW'(N_REQ)) : IW'(sum_s);
      if (!found_s && req_valid[cand_s]) begin
        gnt_s[cand_s] = 1'b1;
        gidx_s        = cand_s;
        found_s       = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    if (found_s) begin
      ptr_d = (gidx_s == IW'(N_REQ - 1)) ? '0 : gidx_s + IW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer advances only on a handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: the last valid index scanned (highest) wins
  always_comb begin
    gnt_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt_s = req_valid[i] ? (N_REQ'(1) << i) : gnt_s;
    end
  end
`endif

  assign req_ready = gnt_s;

  // One-hot grant makes an AND-OR mux sufficient and yields zeros when idle
  always_comb begin
    mem_en    = |gnt_s;
    mem_we    = |(gnt_s & req_we);
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      mem_addr  = mem_addr  | ({AW{gnt_s[i]}} & req_addr[i*AW +: AW]);
      mem_wdata = mem_wdata | ({DW{gnt_s[i]}} & req_wdata[i*DW +: DW]);
      mem_be    = mem_be    | ({BW{gnt_s[i]}} & req_be[i*BW +: BW]);
    end
  end

  // Each tag entry keeps its id one-hot, so an all-zero vector is an invalid entry
  logic [N_REQ-1:0] sel_q [RD_LAT];
  logic [N_REQ-1:0] sel_d [RD_LAT];
  logic             we_q  [RD_LAT];
  logic             we_d  [RD_LAT];

  // Shift tags one stage per cycle, dropping any whose requester is killed this cycle
  always_comb begin
    sel_d    = '{default: '0};
    we_d     = '{default: 1'b0};
    sel_d[0] = gnt_s & ~rsp_kill;
    we_d[0]  = mem_we & (|sel_d[0]);
    for (int k = 1; k < RD_LAT; k++) begin
      sel_d[k] = sel_q[k-1] & ~rsp_kill;
      we_d[k]  = we_q[k-1] & (|sel_d[k]);
    end
  end

  // Tag pipeline registers; the last stage is the response strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < RD_LAT; k++) begin
        sel_q[k] <= '0;
        we_q[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < RD_LAT; k++) begin
        sel_q[k] <= sel_d[k];
        we_q[k]  <= we_d[k];
      end
    end
  end

  assign rsp_valid = sel_q[RD_LAT-1];
  assign rsp_we    = we_q[RD_LAT-1];
  // Read data arrives in the same cycle as the registered strobe, so it is gated rather than re-registered
  assign rsp_data  = ((|sel_q[RD_LAT-1]) && !we_q[RD_LAT-1]) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter (N_REQ=2, RD_LAT=2, DW=32): vector table for grant/issue, queue scoreboard for responses.
module tb_mem_port_arbiter;

  localparam int N   = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N*4-1:0]  req_be = '0;
  logic [N-1:0]    rsp_kill = '0;
  logic [N-1:0]    rsp_valid;
  logic            rsp_we;
  logic [DW-1:0]   rsp_data;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [3:0]      mem_be;
  logic [DW-1:0]   mem_rdata;

  mem_port_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_kill(rsp_kill), .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_data(rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  valid;
    logic [1:0]  we;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] wd1;
    logic [3:0]  be1;
    logic [1:0]  kill;
    logic [1:0]  exp_rdy;
  } vec_t;

  typedef struct {
    int          due;
    int          id;
    logic        we;
    logic [31:0] data;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] ma1 = 32'h0;
  logic [31:0] ma2 = 32'h0;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ((a ^ 32'h3C3C_0000) | 32'h1);
  endfunction

  // Memory model: read data appears two cycles after the access
  always @(posedge clk) begin
    cyc <= cyc + 1;
    ma1 <= mem_en ? mem_addr : 32'hFFFF_FFF0;
    ma2 <= ma1;
  end
  assign mem_rdata = mdata(ma2);

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic [1:0] v, input logic [1:0] w,
                              input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] wd1,
                              input logic [3:0] be1, input logic [1:0] k, input logic [1:0] e);
    vec_t t;
    t.rst = r; t.valid = v; t.we = w; t.a0 = a0; t.a1 = a1;
    t.wd1 = wd1; t.be1 = be1; t.kill = k; t.exp_rdy = e;
    tbl.push_back(t);
  endfunction

  function automatic void idle(input int n);
    for (int i = 0; i < n; i++) add(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 4'h0, 2'b00, 2'b00);
  endfunction

  // Response scoreboard, compared every cycle away from the active edge
  always @(negedge clk) begin
    logic [1:0]  ev;
    logic        ew;
    logic [31:0] ed;
    ev = 2'b00;
    ew = 1'b0;
    ed = 32'h0;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      ev[sbq[0].id] = 1'b1;
      ew = sbq[0].we;
      ed = sbq[0].data;
      void'(sbq.pop_front());
    end
    check("rsp_valid", 128'(rsp_valid), 128'(ev));
    check("rsp_we",    128'(rsp_we),    128'(ew));
    check("rsp_data",  128'(rsp_data),  128'(ed));
  end

  initial begin
    vec_t        v;
    logic [69:0] em;
    exp_t        e;
    exp_t        keep[$];

    idle(1);
    add(1'b0, 2'b01, 2'b00, 32'h100, 32'h0, 32'h0, 4'h0, 2'b00, 2'b01);
    idle(2);
`ifdef MEM_ARB_RR_EN
    add(1'b0, 2'b11, 2'b00, 32'h200, 32'h300, 32'h0, 4'h0, 2'b00, 2'b10);
    add(1'b0, 2'b11, 2'b00, 32'h204, 32'h304, 32'h0, 4'h0, 2'b00, 2'b01);
    add(1'b0, 2'b11, 2'b00, 32'h208, 32'h308, 32'h0, 4'h0, 2'b00, 2'b10);
`else
    add(1'b0, 2'b11, 2'b00, 32'h200, 32'h300, 32'h0, 4'h0, 2'b00, 2'b10);
    add(1'b0, 2'b11, 2'b00, 32'h204, 32'h304, 32'h0, 4'h0, 2'b00, 2'b10);
    add(1'b0, 2'b11, 2'b00, 32'h208, 32'h308, 32'h0, 4'h0, 2'b00, 2'b10);
`endif
    add(1'b0, 2'b01, 2'b00, 32'h20C, 32'h0, 32'h0, 4'h0, 2'b00, 2'b01);
    add(1'b0, 2'b10, 2'b10, 32'h0, 32'h40, 32'h12345678, 4'b0011, 2'b00, 2'b10);
    idle(2);
    add(1'b0, 2'b01, 2'b00, 32'h500, 32'h0, 32'h0, 4'h0, 2'b00, 2'b01);
    add(1'b0, 2'b11, 2'b00, 32'h504, 32'h600, 32'h0, 4'h0, 2'b01, 2'b10);
    add(1'b0, 2'b01, 2'b00, 32'h508, 32'h0, 32'h0, 4'h0, 2'b00, 2'b01);
    idle(2);
    add(1'b0, 2'b01, 2'b00, 32'h700, 32'h0, 32'h0, 4'h0, 2'b01, 2'b01);
    idle(2);
    add(1'b0, 2'b01, 2'b00, 32'h800, 32'h0, 32'h0, 4'h0, 2'b00, 2'b01);
    add(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 4'h0, 2'b00, 2'b00);
    add(1'b0, 2'b01, 2'b00, 32'h900, 32'h0, 32'h0, 4'h0, 2'b00, 2'b01);
    idle(2);
    add(1'b0, 2'b10, 2'b00, 32'h0, 32'hA00, 32'h0, 4'h0, 2'b00, 2'b10);
    add(1'b0, 2'b01, 2'b00, 32'hA04, 32'h0, 32'h0, 4'h0, 2'b00, 2'b01);
    add(1'b0, 2'b10, 2'b10, 32'h0, 32'hA08, 32'hCAFEF00D, 4'b1100, 2'b00, 2'b10);
    add(1'b0, 2'b10, 2'b00, 32'h0, 32'hA0C, 32'h0, 4'h0, 2'b00, 2'b10);
    idle(3);
    add(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 4'h0, 2'b00, 2'b00);
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      add(1'b0, 2'b11, 2'b00, 32'hB00 + 32'(4*k), 32'hC00 + 32'(4*k), 32'h0, 4'h0, 2'b00,
          (k % 2 == 0) ? 2'b01 : 2'b10);
`else
      add(1'b0, 2'b11, 2'b00, 32'hB00 + 32'(4*k), 32'hC00 + 32'(4*k), 32'h0, 4'h0, 2'b00, 2'b10);
`endif
    end
    idle(3);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    for (int r = 0; r < tbl.size(); r++) begin
      v = tbl[r];
      @(posedge clk);
      #1;
      rst       = v.rst;
      req_valid = v.valid;
      req_we    = v.we;
      req_addr  = {v.a1, v.a0};
      req_wdata = {v.wd1, ~v.a0};
      req_be    = {v.be1, 4'hF};
      rsp_kill  = v.kill;
      #1;
      if (v.exp_rdy == 2'b10)      em = {1'b1, v.we[1], v.a1, v.wd1, v.be1};
      else if (v.exp_rdy == 2'b01) em = {1'b1, v.we[0], v.a0, ~v.a0, 4'hF};
      else                         em = '0;
      check($sformatf("row%0d req_ready", r), 128'(req_ready), 128'(v.exp_rdy));
      check($sformatf("row%0d mem_port", r), 128'({mem_en, mem_we, mem_addr, mem_wdata, mem_be}), 128'(em));
      if (v.exp_rdy != 2'b00) begin
        e.due  = cyc + LAT;
        e.id   = (v.exp_rdy == 2'b10) ? 1 : 0;
        e.we   = v.we[e.id];
        e.data = e.we ? 32'h0 : mdata((e.id == 1) ? v.a1 : v.a0);
        sbq.push_back(e);
      end
      keep = {};
      foreach (sbq[j]) begin
        if (!(sbq[j].due > cyc && (v.rst || v.kill[sbq[j].id]))) keep.push_back(sbq[j]);
      end
      sbq = keep;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("drain", 128'(sbq.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
